mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory between the IF stage (instruction fetch) and the MEM stage (loads/stores).
- The MEM-stage data path produces d_addr/d_wdata/d_wmask/d_we; this block registers them, issues one transaction at a time on the memory port, and returns read data.
- It raises stall_if/stall_mem until the owning requester receives its ack.
- Data accesses have priority over fetches. A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between instruction fetch (IF) and the
// load/store stage (MEM). One transaction is in flight at a time. Data
// accesses win arbitration, but a starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants made while a fetch was waiting.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   if_req/if_addr    fetch request, held until if_ack
//   if_ack/if_rdata   one-cycle completion pulse and fetched word (held)
//   d_req/d_we/d_wmask/d_addr/d_wdata
//                     load/store request, held until d_ack
//   d_ack/d_rdata     one-cycle completion pulse and load data (held)
//   stall_if          if_req & ~if_ack
//   stall_mem         d_req & ~d_ack
//   mem_valid/mem_ready/mem_we/mem_wmask/mem_addr/mem_wdata
//                     registered command channel (valid/ready handshake)
//   mem_rvalid/mem_rdata
//                     response: read data valid or write complete
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction fetch port
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [DATA_WIDTH-1:0] if_rdata,
   // data port
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [3:0]            d_wmask,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   // pipeline stalls
   output logic                  stall_if,
   output logic                  stall_mem,
   // memory port
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_we,
   output logic [3:0]            mem_wmask,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE_I = 3'd1;
   localparam logic [2:0] WAIT_I  = 3'd2;
   localparam logic [2:0] ISSUE_D = 3'd3;
   localparam logic [2:0] WAIT_D  = 3'd4;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [2:0] state;
   logic [3:0] starve_cnt;

   logic starve_hit;
   logic grant_d;
   logic ack_cycle;
   logic issue_st;
   logic wait_st;
   logic is_d;
   logic complete;

   // Fetch is forced only when it is actually waiting and the data side has
   // used up its run of consecutive grants.
   assign starve_hit = if_req && (starve_cnt == STARVE_MAX);
   assign grant_d    = d_req && !starve_hit;

   // The cycle in which an ack is visible is spent in IDLE without granting,
   // so the acked requester can drop or change its request first.
   assign ack_cycle  = if_ack || d_ack;

   assign issue_st   = (state == ISSUE_I) || (state == ISSUE_D);
   assign wait_st    = (state == WAIT_I)  || (state == WAIT_D);
   assign is_d       = (state == ISSUE_D) || (state == WAIT_D);

   // A zero-latency memory may answer in the same cycle it accepts the
   // command; that response finishes the transaction directly.
   assign complete   = (issue_st && mem_ready && mem_rvalid) ||
                       (wait_st  && mem_rvalid);

   assign stall_if   = if_req && !if_ack;
   assign stall_mem  = d_req  && !d_ack;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is an ordinary branch evaluated on
      // the clock edge rather than an entry in the sensitivity list.
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_wmask  <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         // acks are single-cycle pulses unless a completion re-arms them
         if_ack <= 1'b0;
         d_ack  <= 1'b0;

         case (state)
            IDLE: begin
               if (!if_req) begin
                  starve_cnt <= '0;
               end
               if (!ack_cycle) begin
                  if (grant_d) begin
                     state     <= ISSUE_D;
                     mem_valid <= 1'b1;
                     mem_we    <= d_we;
                     mem_wmask <= d_we ? d_wmask : 4'b0000;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     if (if_req && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + 4'd1;
                     end
                  end else if (if_req) begin
                     state      <= ISSUE_I;
                     mem_valid  <= 1'b1;
                     mem_we     <= 1'b0;
                     mem_wmask  <= 4'b0000;
                     mem_addr   <= if_addr;
                     starve_cnt <= '0;
                  end
               end
            end

            ISSUE_I, ISSUE_D: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (!mem_rvalid) begin
                     state <= is_d ? WAIT_D : WAIT_I;
                  end
               end
            end

            WAIT_I, WAIT_D: begin
               // waiting for mem_rvalid; completion handled below
            end

            default: begin
               state     <= IDLE;
               mem_valid <= 1'b0;
            end
         endcase

         if (complete) begin
            state <= IDLE;
            if (is_d) begin
               d_ack <= 1'b1;
               // stores complete without touching the held load data
               if (!mem_we) begin
                  d_rdata <= mem_rdata;
               end
            end else begin
               if_ack   <= 1'b1;
               if_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A behavioural memory answers command
// handshakes with a programmable ready delay and either one-cycle or
// zero-latency responses; it can be switched off so a scenario can drive the
// memory response pins by hand. Each scenario task checks its own results.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;

   typedef struct packed {
      logic          we;
      logic [3:0]    wmask;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [3:0]    d_wmask = 4'b0000;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          stall_if;
   logic          stall_mem;
   logic          mem_valid;
   logic          mem_ready;
   logic          mem_we;
   logic [3:0]    mem_wmask;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;

   // memory model controls and hand-driven alternatives
   logic          model_en = 1'b1;
   int            ready_delay = 0;
   logic          zero_lat = 1'b0;
   logic          model_ready = 1'b0;
   logic          model_rvalid = 1'b0;
   logic [DW-1:0] model_rdata = '0;
   logic          man_ready = 1'b0;
   logic          man_rvalid = 1'b0;
   logic [DW-1:0] man_rdata = '0;

   logic [DW-1:0] mem_model [logic [AW-1:0]];
   cmd_t          log_q [$];

   int n_cmp = 0;
   int n_err = 0;
   int d_ack_cycles = 0;
   int if_ack_cycles = 0;

   assign mem_ready  = model_en ? model_ready  : man_ready;
   assign mem_rvalid = model_en ? model_rvalid : man_rvalid;
   assign mem_rdata  = model_en ? model_rdata  : man_rdata;

   mem_port_arbiter #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .STARVE_LIMIT(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_wmask   (d_wmask),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_we    (mem_we),
      .mem_wmask (mem_wmask),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // ack activity, counted in cycles so an over-long pulse also shows up
   always @(negedge clk) begin
      if (d_ack)  d_ack_cycles++;
      if (if_ack) if_ack_cycles++;
   end

   // behavioural memory: drives handshake/response away from the rising edge
   int            wcnt = 0;
   logic          pend = 1'b0;
   logic [DW-1:0] pend_data = '0;

   always @(negedge clk) begin
      logic [DW-1:0] word;
      model_ready  = 1'b0;
      model_rvalid = 1'b0;
      if (!rst) begin
         pend = 1'b0;
         wcnt = 0;
      end else if (model_en) begin
         if (pend) begin
            model_rvalid = 1'b1;
            model_rdata  = pend_data;
            pend         = 1'b0;
         end else if (mem_valid) begin
            if (wcnt < ready_delay) begin
               wcnt++;
            end else begin
               wcnt = 0;
               model_ready = 1'b1;
               log_q.push_back('{mem_we, mem_wmask, mem_addr, mem_wdata});
               word = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
               if (mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_wmask[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
                  mem_model[mem_addr] = word;
               end
               if (zero_lat) begin
                  model_rvalid = 1'b1;
                  model_rdata  = word;
               end else begin
                  pend      = 1'b1;
                  pend_data = word;
               end
            end
         end
      end
   end

   task automatic wait_d_ack(input int budget, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (d_ack) seen = 1'b1;
      end
   endtask

   task automatic wait_if_ack(input int budget, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (if_ack) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
      n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      n_cmp++; if (mem_wmask !== 4'b0000) begin n_err++; $display("FAIL rst_mem_wmask: got %b want 0000", mem_wmask); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      n_cmp++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin n_err++; $display("FAIL rst_acks: got if=%b d=%b want 0 0", if_ack, d_ack); end
      n_cmp++; if (if_rdata !== 32'h0) begin n_err++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
      n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (mem_valid !== 1'b0 || stall_if !== 1'b0 || stall_mem !== 1'b0) begin
         n_err++; $display("FAIL idle_quiet: got valid=%b sif=%b smem=%b want 0 0 0", mem_valid, stall_if, stall_mem);
      end
   endtask

   task automatic test_load;
      bit   seen;
      int   base;
      cmd_t c;
      mem_model[32'h100] = 32'hDEADBEEF;
      log_q.delete();
      base = d_ack_cycles;
      d_req = 1'b1; d_we = 1'b0; d_wmask = 4'b1111; d_addr = 32'h100; d_wdata = 32'h1111_1111;
      @(negedge clk);
      n_cmp++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL load_stall_before: got %b want 1", stall_mem); end
      wait_d_ack(40, seen);
      n_cmp++; if (!seen) begin n_err++; $display("FAIL load_ack: got timeout want d_ack"); end
      n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL load_stall_at_ack: got %b want 0", stall_mem); end
      n_cmp++; if (d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_rdata: got %h want deadbeef", d_rdata); end
      d_req = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (d_ack_cycles - base !== 1) begin n_err++; $display("FAIL load_ack_count: got %0d want 1", d_ack_cycles - base); end
      c = (log_q.size() > 0) ? log_q[0] : '0;
      n_cmp++; if (log_q.size() !== 1) begin n_err++; $display("FAIL load_cmd_count: got %0d want 1", log_q.size()); end
      n_cmp++; if (c.addr !== 32'h100 || c.we !== 1'b0) begin n_err++; $display("FAIL load_cmd: got addr=%h we=%b want 100 0", c.addr, c.we); end
      n_cmp++; if (c.wmask !== 4'b0000) begin n_err++; $display("FAIL load_wmask_forced: got %b want 0000", c.wmask); end
   endtask

   task automatic test_store;
      bit seen = 1'b0;
      int base, nvalid = 0, unstable = 0;
      mem_model[32'h204] = 32'h0;
      ready_delay = 3;
      base = d_ack_cycles;
      d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0011; d_addr = 32'h204; d_wdata = 32'h1234ABCD;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (mem_valid) begin
            nvalid++;
            if ({mem_we, mem_wmask, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h204, 32'h1234ABCD})
               unstable++;
         end
         if (d_ack) seen = 1'b1;
      end
      d_req = 1'b0;
      ready_delay = 0;
      n_cmp++; if (!seen) begin n_err++; $display("FAIL store_ack: got timeout want d_ack"); end
      n_cmp++; if (nvalid !== 4) begin n_err++; $display("FAIL store_valid_cycles: got %0d want 4", nvalid); end
      n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL store_cmd_stable: got %0d bad cycles want 0", unstable); end
      n_cmp++; if (d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_rdata_kept: got %h want deadbeef", d_rdata); end
      repeat (4) @(negedge clk);
      n_cmp++; if (d_ack_cycles - base !== 1) begin n_err++; $display("FAIL store_ack_count: got %0d want 1", d_ack_cycles - base); end
      n_cmp++; if (mem_model[32'h204] !== 32'h0000ABCD) begin n_err++; $display("FAIL store_written: got %h want 0000abcd", mem_model[32'h204]); end
   endtask

   task automatic test_conflict;
      string ord = "";
      bit    i_done = 1'b0;
      int    stall_bad = 0;
      mem_model[32'h300] = 32'h0000_0013;
      mem_model[32'h400] = 32'hCAFEF00D;
      log_q.delete();
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      for (int c = 0; c < 60 && !i_done; c++) begin
         @(negedge clk);
         if (!if_ack && stall_if !== 1'b1) stall_bad++;
         if (d_ack) begin ord = {ord, "D"}; d_req = 1'b0; end
         if (if_ack) begin ord = {ord, "I"}; if_req = 1'b0; i_done = 1'b1; end
      end
      if_req = 1'b0; d_req = 1'b0;
      n_cmp++; if (ord != "DI") begin n_err++; $display("FAIL conflict_order: got '%s' want 'DI'", ord); end
      n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL conflict_stall_if: got %0d low cycles want 0", stall_bad); end
      n_cmp++; if (if_rdata !== 32'h13 || d_rdata !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL conflict_data: got if=%h d=%h want 00000013 cafef00d", if_rdata, d_rdata);
      end
      n_cmp++; if (log_q.size() !== 2 || log_q[0].addr !== 32'h400 || log_q[1].addr !== 32'h300) begin
         n_err++; $display("FAIL conflict_cmds: got %0d cmds want 400 then 300", log_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_starve;
      string pat = "";
      bit    i_done = 1'b0, fin = 1'b0;
      int    nd = 0, d_before = -1;
      mem_model[32'h500] = 32'h600D0500;
      mem_model[32'h600] = 32'h0BAD0600;
      log_q.delete();
      if_req = 1'b1; if_addr = 32'h500;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(negedge clk);
         if (d_ack) begin
            nd++;
            if (i_done) begin d_req = 1'b0; fin = 1'b1; end
         end
         if (if_ack) begin i_done = 1'b1; if_req = 1'b0; d_before = nd; end
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (4) @(negedge clk);
      foreach (log_q[k]) pat = {pat, (log_q[k].addr == 32'h500) ? "I" : "D"};
      n_cmp++; if (!fin) begin n_err++; $display("FAIL starve_done: got timeout want I then D acks"); end
      n_cmp++; if (d_before !== 4) begin n_err++; $display("FAIL starve_d_before_i: got %0d want 4", d_before); end
      n_cmp++; if (pat != "DDDDID") begin n_err++; $display("FAIL starve_pattern: got '%s' want 'DDDDID'", pat); end
      n_cmp++; if (if_rdata !== 32'h600D0500) begin n_err++; $display("FAIL starve_if_rdata: got %h want 600d0500", if_rdata); end
   endtask

   task automatic test_reset_mid;
      bit seen = 1'b0;
      int base;
      model_en = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (mem_valid) seen = 1'b1;
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL rmid_valid: got timeout want mem_valid"); end
      man_ready = 1'b1;
      @(negedge clk);
      man_ready = 1'b0;
      n_cmp++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL rmid_in_wait: got valid=%b want 0", mem_valid); end
      rst = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      base = d_ack_cycles;
      man_rvalid = 1'b1; man_rdata = 32'h9999_9999;
      @(negedge clk);
      man_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (d_ack_cycles !== base) begin n_err++; $display("FAIL rmid_no_ack: got %0d ack cycles want 0", d_ack_cycles - base); end
      n_cmp++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin n_err++; $display("FAIL rmid_rdata: got d=%h if=%h want 0 0", d_rdata, if_rdata); end
      n_cmp++; if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
         n_err++; $display("FAIL rmid_cmd_reset: got valid=%b addr=%h we=%b want 0 0 0", mem_valid, mem_addr, mem_we);
      end
      model_en = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      wait_d_ack(40, seen);
      d_req = 1'b0;
      n_cmp++; if (!seen || d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rmid_recover: got ack=%b data=%h want 1 deadbeef", seen, d_rdata); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_zero_latency;
      bit seen = 1'b0;
      int t0 = -1, t1 = -1, nvalid = 0;
      mem_model[32'h800] = 32'h00A0B0C0;
      zero_lat = 1'b1;
      if_req = 1'b1; if_addr = 32'h800;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         if (mem_valid) begin nvalid++; if (t0 < 0) t0 = c; end
         if (if_ack) begin t1 = c; seen = 1'b1; if_req = 1'b0; end
      end
      if_req = 1'b0; zero_lat = 1'b0;
      n_cmp++; if (!seen) begin n_err++; $display("FAIL zl_ack: got timeout want if_ack"); end
      n_cmp++; if (t1 - t0 !== 1) begin n_err++; $display("FAIL zl_latency: got %0d cycles valid->ack want 1", t1 - t0); end
      n_cmp++; if (nvalid !== 1) begin n_err++; $display("FAIL zl_valid_cycles: got %0d want 1", nvalid); end
      n_cmp++; if (if_rdata !== 32'h00A0B0C0) begin n_err++; $display("FAIL zl_rdata: got %h want 00a0b0c0", if_rdata); end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_load();
      test_store();
      test_conflict();
      test_starve();
      test_reset_mid();
      test_zero_latency();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
